pcx_cpx_txn_tracker: RTL and testbench

Parametrised per-CPU PCX/CPX transaction tracker for the CMP verification environment. It sits on the SPARC-core/crossbar boundary alongside the packet monitors and counts outstanding response-expecting PCX requests per CPU against their CPX returns. It flags overflow, underflow and response timeouts, and gives the end-of-test logic a quiescence indication. An optional per-packet trace is compiled in by macro.

---
 rtl/pcx_cpx_txn_tracker.sv | 160 ++++++++++++++++
 tb/tb_pcx_cpx_txn_tracker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcx_cpx_txn_tracker.sv
// Per-CPU PCX/CPX outstanding-transaction tracker with overflow/underflow/timeout flags.
// Optional per-packet trace enabled by defining PCXCPX_TRACE_EN.
module pcx_cpx_txn_tracker #(
    parameter int          NUM_CPU  = 8,
    parameter int          MAX_OUT  = 8,
    parameter int          TIMEOUT  = 4096,
    parameter int          CNT_W    = 32,
    parameter logic [31:0] REQ_MASK = 32'h0000_0077,
    parameter logic [15:0] RET_MASK = 16'h0055,
    localparam int         OUT_W    = $clog2(MAX_OUT + 1),
    localparam int         CPU_W    = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mon_en,
    input  logic                     err_clr,
    input  logic [NUM_CPU-1:0]       pcx_vld,
    input  logic [5*NUM_CPU-1:0]     pcx_rqtype,
    input  logic [NUM_CPU-1:0]       cpx_vld,
    input  logic [4*NUM_CPU-1:0]     cpx_rqtype,
    output logic [OUT_W*NUM_CPU-1:0] outstanding,
    output logic [NUM_CPU-1:0]       err_ovf,
    output logic [NUM_CPU-1:0]       err_udf,
    output logic [NUM_CPU-1:0]       err_tmo,
    output logic                     any_err,
    output logic [CPU_W-1:0]         first_err_cpu,
    output logic                     all_idle,
    output logic [CNT_W-1:0]         pcx_cnt,
    output logic [CNT_W-1:0]         cpx_cnt
);

    localparam int               POP_W   = $clog2(NUM_CPU + 1);
    localparam int               SUM_W   = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [OUT_W-1:0] MAX_CNT = OUT_W'(MAX_OUT);
    localparam logic [15:0]      TMO     = 16'(TIMEOUT);
    localparam logic [15:0]      TMO_M1  = 16'(TIMEOUT - 1);

    logic [OUT_W-1:0]   cnt_p1   [NUM_CPU];
    logic [15:0]        wd_p1    [NUM_CPU];
    logic [OUT_W-1:0]   cnt_nxt  [NUM_CPU];
    logic [15:0]        wd_nxt   [NUM_CPU];
    logic [NUM_CPU-1:0] inc, dec;
    logic [NUM_CPU-1:0] ovf_set, udf_set, tmo_set, new_err;
    logic [CPU_W-1:0]   first_nxt;

    function automatic logic [POP_W-1:0] popcount(input logic [NUM_CPU-1:0] v);
        logic [POP_W-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_CPU; i++) p = p + POP_W'(v[i]);
        return p;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [POP_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        return (s > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // stage 0: decode tracked packets and compute next counter/watchdog state
    always_comb begin
        first_nxt = '0;
        for (int n = 0; n < NUM_CPU; n++) begin
            inc[n]     = mon_en & pcx_vld[n] & REQ_MASK[pcx_rqtype[5*n +: 5]];
            dec[n]     = mon_en & cpx_vld[n] & RET_MASK[cpx_rqtype[4*n +: 4]];
            cnt_nxt[n] = cnt_p1[n];
            wd_nxt[n]  = wd_p1[n];
            ovf_set[n] = 1'b0;
            udf_set[n] = 1'b0;
            tmo_set[n] = 1'b0;
            if (inc[n] && !dec[n]) begin
                if (cnt_p1[n] == MAX_CNT) ovf_set[n] = 1'b1;
                else                      cnt_nxt[n] = cnt_p1[n] + OUT_W'(1);
            end else if (dec[n] && !inc[n]) begin
                if (cnt_p1[n] == '0) udf_set[n] = 1'b1;
                else                 cnt_nxt[n] = cnt_p1[n] - OUT_W'(1);
            end
            // watchdog runs off the registered count, so it starts one cycle after the first request
            if (mon_en) begin
                if (cnt_p1[n] == '0 || dec[n]) begin
                    wd_nxt[n] = '0;
                end else if (wd_p1[n] != TMO) begin
                    wd_nxt[n]  = wd_p1[n] + 16'd1;
                    tmo_set[n] = (wd_p1[n] == TMO_M1);
                end
            end
        end
        new_err = ovf_set | udf_set | tmo_set;
        for (int n = NUM_CPU - 1; n >= 0; n--) begin
            if (new_err[n]) first_nxt = CPU_W'(n);
        end
    end

    // stage 1: registered tracking state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NUM_CPU; n++) begin
                cnt_p1[n] <= '0;
                wd_p1[n]  <= '0;
            end
            err_ovf       <= '0;
            err_udf       <= '0;
            err_tmo       <= '0;
            first_err_cpu <= '0;
            pcx_cnt       <= '0;
            cpx_cnt       <= '0;
        end else begin
            for (int n = 0; n < NUM_CPU; n++) begin
                cnt_p1[n] <= cnt_nxt[n];
                wd_p1[n]  <= wd_nxt[n];
            end
            // a clear in the same cycle as a new error wins; the new error is dropped
            if (err_clr) begin
                err_ovf       <= '0;
                err_udf       <= '0;
                err_tmo       <= '0;
                first_err_cpu <= '0;
            end else begin
                err_ovf <= err_ovf | ovf_set;
                err_udf <= err_udf | udf_set;
                err_tmo <= err_tmo | tmo_set;
                if (!any_err && (new_err != '0)) first_err_cpu <= first_nxt;
            end
            if (mon_en) begin
                pcx_cnt <= sat_add(pcx_cnt, popcount(pcx_vld));
                cpx_cnt <= sat_add(cpx_cnt, popcount(cpx_vld));
            end
        end
    end

    always_comb begin
        outstanding = '0;
        all_idle    = 1'b1;
        for (int n = 0; n < NUM_CPU; n++) begin
            outstanding[OUT_W*n +: OUT_W] = cnt_p1[n];
            if (cnt_p1[n] != '0) all_idle = 1'b0;
        end
    end

    assign any_err = (err_ovf != '0) || (err_udf != '0) || (err_tmo != '0);

`ifdef PCXCPX_TRACE_EN
    always @(posedge clk) begin
        if (!rst) begin
            for (int n = 0; n < NUM_CPU; n++) begin
                if (inc[n])
                    $display("%0t cpu %0d PCX rqtype %b count %0d", $time, n,
                             pcx_rqtype[5*n +: 5], cnt_nxt[n]);
                if (dec[n])
                    $display("%0t cpu %0d CPX rqtype %b count %0d", $time, n,
                             cpx_rqtype[4*n +: 4], cnt_nxt[n]);
                if (!err_clr && ovf_set[n]) $display("%0t PCXCPX ERROR overflow cpu %0d", $time, n);
                if (!err_clr && udf_set[n]) $display("%0t PCXCPX ERROR underflow cpu %0d", $time, n);
                if (!err_clr && tmo_set[n]) $display("%0t PCXCPX ERROR timeout cpu %0d", $time, n);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pcx_cpx_txn_tracker.sv
// Scoreboard bench for pcx_cpx_txn_tracker: directed scenarios plus random traffic
// checked against a cycle-level behavioural model of the tracking rules.
module tb_pcx_cpx_txn_tracker;
    localparam int NC = 8;
    localparam int MO = 8;
    localparam int TO = 16;
    localparam int CW = 4;
    localparam int OW = 4;

    logic            clk, rst, mon_en, err_clr;
    logic [NC-1:0]   pcx_vld, cpx_vld;
    logic [5*NC-1:0] pcx_rqtype;
    logic [4*NC-1:0] cpx_rqtype;
    logic [OW*NC-1:0] outstanding;
    logic [NC-1:0]   err_ovf, err_udf, err_tmo;
    logic            any_err, all_idle;
    logic [2:0]      first_err_cpu;
    logic [CW-1:0]   pcx_cnt, cpx_cnt;

    pcx_cpx_txn_tracker #(.NUM_CPU(NC), .MAX_OUT(MO), .TIMEOUT(TO), .CNT_W(CW),
                          .REQ_MASK(32'h0000_0077), .RET_MASK(16'h0055)) dut (
        .clk(clk), .rst(rst), .mon_en(mon_en), .err_clr(err_clr),
        .pcx_vld(pcx_vld), .pcx_rqtype(pcx_rqtype),
        .cpx_vld(cpx_vld), .cpx_rqtype(cpx_rqtype),
        .outstanding(outstanding), .err_ovf(err_ovf), .err_udf(err_udf),
        .err_tmo(err_tmo), .any_err(any_err), .first_err_cpu(first_err_cpu),
        .all_idle(all_idle), .pcx_cnt(pcx_cnt), .cpx_cnt(cpx_cnt));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] outs;
        logic [7:0]  ovf, udf, tmo;
        logic        any;
        logic [2:0]  first;
        logic        idle;
        logic [3:0]  pc, cc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int fails  = 0;

    logic [31:0] req_m = 32'h0000_0077;
    logic [15:0] ret_m = 16'h0055;

    // reference model state
    int       m_cnt[NC];
    int       m_wd[NC];
    bit [7:0] m_ovf, m_udf, m_tmo;
    int       m_first, m_pc, m_cc;

    // next-cycle stimulus
    bit            nx_rst, nx_en, nx_clr;
    bit [NC-1:0]   nx_pv, nx_cv;
    bit [5*NC-1:0] nx_pr;
    bit [4*NC-1:0] nx_cr;

    function automatic void model_reset();
        for (int n = 0; n < NC; n++) begin
            m_cnt[n] = 0;
            m_wd[n]  = 0;
        end
        m_ovf = 0; m_udf = 0; m_tmo = 0;
        m_first = 0; m_pc = 0; m_cc = 0;
    endfunction

    function automatic void model_step();
        bit [7:0] no, nu, nt;
        bit inc, dec, anyold;
        int rq;
        no = 0; nu = 0; nt = 0;
        if (nx_en) begin
            for (int n = 0; n < NC; n++) begin
                rq  = int'(nx_pr[5*n +: 5]);
                inc = nx_pv[n] && req_m[rq];
                rq  = int'(nx_cr[4*n +: 4]);
                dec = nx_cv[n] && ret_m[rq];
                if (m_cnt[n] == 0 || dec) m_wd[n] = 0;
                else if (m_wd[n] < TO) begin
                    m_wd[n]++;
                    if (m_wd[n] == TO) nt[n] = 1;
                end
                if (inc && !dec) begin
                    if (m_cnt[n] == MO) no[n] = 1; else m_cnt[n]++;
                end
                if (dec && !inc) begin
                    if (m_cnt[n] == 0) nu[n] = 1; else m_cnt[n]--;
                end
            end
            m_pc = m_pc + $countones(nx_pv);
            m_cc = m_cc + $countones(nx_cv);
            if (m_pc > 15) m_pc = 15;
            if (m_cc > 15) m_cc = 15;
        end
        anyold = (m_ovf != 0) || (m_udf != 0) || (m_tmo != 0);
        if (nx_clr) begin
            m_ovf = 0; m_udf = 0; m_tmo = 0; m_first = 0;
        end else begin
            m_ovf |= no; m_udf |= nu; m_tmo |= nt;
            if (!anyold && (no | nu | nt) != 0) begin
                for (int n = NC - 1; n >= 0; n--)
                    if (no[n] || nu[n] || nt[n]) m_first = n;
            end
        end
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.outs = '0;
        e.idle = 1'b1;
        for (int n = 0; n < NC; n++) begin
            e.outs[4*n +: 4] = 4'(m_cnt[n]);
            if (m_cnt[n] != 0) e.idle = 1'b0;
        end
        e.ovf = m_ovf; e.udf = m_udf; e.tmo = m_tmo;
        e.any = (m_ovf != 0) || (m_udf != 0) || (m_tmo != 0);
        e.first = 3'(m_first);
        e.pc = 4'(m_pc); e.cc = 4'(m_cc);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // apply the staged inputs before the next edge and queue the expected response
    task automatic tick();
        @(negedge clk);
        rst = nx_rst; mon_en = nx_en; err_clr = nx_clr;
        pcx_vld = nx_pv; pcx_rqtype = nx_pr; cpx_vld = nx_cv; cpx_rqtype = nx_cr;
        if (nx_rst) model_reset(); else model_step();
        q.push_back(snap());
    endtask

    task automatic clear_nx();
        nx_rst = 0; nx_en = 1; nx_clr = 0;
        nx_pv = '0; nx_cv = '0; nx_pr = '0; nx_cr = '0;
    endtask

    task automatic pcx_on(input int n, input int rq);
        nx_pv[n] = 1'b1;
        nx_pr[5*n +: 5] = 5'(rq);
    endtask

    task automatic cpx_on(input int n, input int rq);
        nx_cv[n] = 1'b1;
        nx_cr[4*n +: 4] = 4'(rq);
    endtask

    task automatic idle(input int k);
        clear_nx();
        repeat (k) tick();
    endtask

    task automatic do_reset();
        clear_nx();
        nx_rst = 1;
        tick();
        tick();
        idle(1);
    endtask

    // monitor: compare every queued expectation shortly after the edge (or async reset) it refers to
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                chk("outstanding", outstanding, e.outs);
                chk("err_ovf", {24'd0, err_ovf}, {24'd0, e.ovf});
                chk("err_udf", {24'd0, err_udf}, {24'd0, e.udf});
                chk("err_tmo", {24'd0, err_tmo}, {24'd0, e.tmo});
                chk("any_err", {31'd0, any_err}, {31'd0, e.any});
                chk("first_err_cpu", {29'd0, first_err_cpu}, {29'd0, e.first});
                chk("all_idle", {31'd0, all_idle}, {31'd0, e.idle});
                chk("pcx_cnt", {28'd0, pcx_cnt}, {28'd0, e.pc});
                chk("cpx_cnt", {28'd0, cpx_cnt}, {28'd0, e.cc});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks, %0d failures", checks, fails);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 0; mon_en = 0; err_clr = 0;
        pcx_vld = '0; cpx_vld = '0; pcx_rqtype = '0; cpx_rqtype = '0;
        model_reset();
        do_reset();

        // CPU 3 fill and drain
        repeat (3) begin clear_nx(); pcx_on(3, 0); tick(); end
        repeat (3) begin clear_nx(); cpx_on(3, 0); tick(); end
        idle(2);

        // CPU 0 simultaneous request and return
        repeat (2) begin clear_nx(); pcx_on(0, 0); tick(); end
        clear_nx(); pcx_on(0, 0); cpx_on(0, 0); tick();
        idle(1);
        repeat (2) begin clear_nx(); cpx_on(0, 0); tick(); end

        // CPU 5 overflow, clear, drain
        repeat (9) begin clear_nx(); pcx_on(5, 0); tick(); end
        idle(1);
        clear_nx(); nx_clr = 1; tick();
        idle(1);
        repeat (8) begin clear_nx(); cpx_on(5, 0); tick(); end

        // CPU 1 and 6 simultaneous underflow
        clear_nx(); cpx_on(1, 0); cpx_on(6, 0); tick();
        idle(1);
        clear_nx(); nx_clr = 1; tick();

        // CPU 2 timeout with untracked request and a monitoring pause
        clear_nx(); pcx_on(2, 0); tick();
        clear_nx(); pcx_on(2, 9); tick();
        idle(3);
        clear_nx(); nx_en = 0; repeat (5) tick();
        idle(20);
        clear_nx(); nx_clr = 1; tick();
        clear_nx(); cpx_on(2, 0); tick();
        idle(1);

        // packet counter saturation, then asynchronous reset mid-burst
        do_reset();
        clear_nx(); nx_pv = '1; repeat (3) tick();
        nx_rst = 1; tick(); tick();
        idle(2);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            clear_nx();
            nx_en  = ($urandom_range(0, 9) != 0);
            nx_clr = ($urandom_range(0, 63) == 0);
            nx_rst = ($urandom_range(0, 299) == 0);
            nx_pv  = NC'($urandom);
            nx_cv  = NC'($urandom);
            for (int n = 0; n < NC; n++) begin
                if ($urandom_range(0, 1) == 1) nx_pr[5*n +: 5] = 5'($urandom_range(0, 7));
                else                           nx_pr[5*n +: 5] = 5'($urandom);
                if ($urandom_range(0, 1) == 1) nx_cr[4*n +: 4] = 4'($urandom_range(0, 7));
                else                           nx_cr[4*n +: 4] = 4'($urandom);
            end
            tick();
        end
        idle(3);
        @(posedge clk);
        #3;
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
